// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the RV32I 5-stage pipeline.
// Load-use and taken-branch hazards, multi-cycle dmem wait FSM, stall counter.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   id_rs1/rs2        ID source regs, id_uses_rs1/rs2 read qualifiers
//   ex_rd, ex_memread EX destination and load flag
//   ex_branch_taken   branch/jump resolved taken in EX
//   mem_memread/write MEM stage data-memory access
//   dmem_ready        data memory completes access this cycle
//   pc_stall, *_stall hold PC / pipeline registers
//   *_flush           load NOP into pipeline registers
//   dmem_req          data-memory request strobe
//   mem_err           sticky memory timeout error
//   stall_cycles      saturating count of pc_stall cycles

module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_memread,
  input  logic        ex_branch_taken,
  input  logic        mem_memread,
  input  logic        mem_memwrite,
  input  logic        dmem_ready,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_stall,
  output logic        ex_mem_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mem_wb_flush,
  output logic        dmem_req,
  output logic        mem_err,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] wait_q;
  logic [CNT_W-1:0] wait_d;
  logic             err_q;
  logic [31:0]      stall_cnt_q;

  logic mem_acc;
  logic mem_block;
  logic load_use;
  logic sel_blk;
  logic sel_br;
  logic sel_lu;

  assign mem_acc = mem_memread | mem_memwrite;

  always_comb begin
    mem_block = 1'b0;
    unique case (state_q)
      S_IDLE:  mem_block = mem_acc & ~dmem_ready;
      S_WAIT:  mem_block = ~dmem_ready;
      S_ERR:   mem_block = 1'b1;
      default: mem_block = 1'b0;
    endcase
  end

  assign load_use = ex_memread & (ex_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                     (id_uses_rs2 & (id_rs2 == ex_rd)));

  // One-hot priority selects: a frozen EX defers branch and load-use.
  assign sel_blk = mem_block;
  assign sel_br  = ~mem_block & ex_branch_taken;
  assign sel_lu  = ~mem_block & ~ex_branch_taken & load_use;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_d == S_ERR) err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      S_IDLE: begin
        if (mem_acc && !dmem_ready) begin
          state_d = S_WAIT;
          wait_d  = CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (dmem_ready) begin
          state_d = S_IDLE;
          wait_d  = '0;
        end else if (wait_q == TMO) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
        wait_d  = '0;
      end
    endcase
  end

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    dmem_req     = 1'b0;
    if (!rst) begin
      dmem_req = mem_acc & (state_q != S_ERR);
      unique case (1'b1)
        sel_blk: begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_stall  = 1'b1;
          ex_mem_stall = 1'b1;
          mem_wb_flush = 1'b1;
        end
        sel_br: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end
        sel_lu: begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_err      = err_q & ~rst;
  assign stall_cycles = rst ? 32'd0 : stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (pc_stall && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the RV32I 5-stage pipeline. Detects load-use hazards and taken branches, and runs a small FSM for multi-cycle data-memory accesses. Drives the hold and flush inputs of every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable. Also keeps a saturating stall-cycle performance counter and a sticky memory-timeout error.

## Interface
- TIMEOUT, 255: maximum number of MEM_WAIT cycles before error; legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the wait counter.
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction actually reads that source.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_memread  in  1  the EX instruction is a load.
- ex_branch_taken  in  1  branch or jump resolved taken in EX.
- mem_memread, mem_memwrite  in  1 each  the MEM instruction accesses data memory.
- dmem_ready  in  1  data memory completes the current access this cycle.
- pc_stall  out  1  hold PC.
- if_id_stall, id_ex_stall, ex_mem_stall  out  1 each  hold the corresponding register.
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load a NOP into the corresponding register.
- dmem_req  out  1  data-memory request strobe.
- mem_err  out  1  sticky timeout error.
- stall_cycles  out  32  count of cycles with pc_stall=1; saturates at 0xFFFFFFFF.

## Operation
- State register: IDLE, MEM_WAIT, ERROR. Also holds wait_cnt (CNT_W bits) and stall_cycles.
- Outputs are combinational from the current state and inputs.
- Per-cycle terms:
  - mem_acc = mem_memread | mem_memwrite.
  - mem_block = (IDLE & mem_acc & !dmem_ready) | (MEM_WAIT & !dmem_ready) | ERROR.
  - load_use = ex_memread & ex_rd≠0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Priority is mem_block > ex_branch_taken > load_use.
  - **mem_block:** pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_flush = 1. All other flushes = 0; branch and load-use effects are deferred because EX is frozen.
  - **branch (no mem_block):** if_id_flush = id_ex_flush = 1. No stalls.
  - **load_use (no mem_block, no branch):** pc_stall = if_id_stall = id_ex_flush = 1.
  - **Otherwise:** all stall and flush outputs 0.
- dmem_req = mem_acc in IDLE and MEM_WAIT; 0 in ERROR.
- FSM transitions:
  - IDLE → MEM_WAIT when mem_acc & !dmem_ready; wait_cnt ← 1.
  - IDLE stays IDLE when mem_acc & dmem_ready (single-cycle access).
  - MEM_WAIT → IDLE on dmem_ready; wait_cnt ← 0. Stalls drop in that same cycle.
  - MEM_WAIT with !dmem_ready and wait_cnt==TIMEOUT → ERROR; mem_err ← 1.
  - MEM_WAIT with !dmem_ready and wait_cnt<TIMEOUT: wait_cnt ← wait_cnt+1.
  - ERROR: only rst exits. Pipeline stays fully frozen; dmem_ready is ignored.
- stall_cycles increments by 1 each cycle pc_stall=1 and holds at its maximum value.

## Timing
- Reset, in the cycle rst is sampled high: state ← IDLE, wait_cnt ← 0, mem_err ← 0, stall_cycles ← 0.
- While rst=1, all outputs are forced to 0, including dmem_req. Pipeline registers clear on their own reset.
- Reset mid-MEM_WAIT or in ERROR aborts immediately; there is no drain.
- Hazard reaction latency is 0 cycles (same-cycle combinational). State latency is 1 cycle.
- A load-use stall lasts exactly 1 cycle: the next cycle the load has moved to MEM and forwarding covers the dependency.
- A memory access completing after N extra cycles gives N cycles of mem_block.
- Branch and memory wait in the same cycle: no flush while blocked. The flush fires in the dmem_ready cycle, since the branch is still held in EX.
- ex_rd==0 never causes a load-use stall.
- dmem_req must stay high and stable from assertion until the dmem_ready cycle.

## Test plan
- **Reset:** 3 cycles of rst=1 during MEM_WAIT → next cycle state IDLE, all outputs 0, stall_cycles=0.
- **Load-use:** ex_memread=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 → pc_stall=if_id_stall=id_ex_flush=1 for 1 cycle; stall_cycles=1. The same stimulus with ex_rd=0 → no stall.
- **Memory wait:** mem_memread=1, dmem_ready low for 3 cycles then high → 3 cycles of all-stall plus mem_wb_flush; release in cycle 4; dmem_req high for 4 cycles.
- **Branch during wait:** ex_branch_taken=1 with a 2-cycle memory wait → no flush for 2 cycles; if_id_flush=id_ex_flush=1 in the dmem_ready cycle.
- **Timeout:** TIMEOUT=4, dmem_ready held 0 → ERROR entered after the 4th wait cycle; mem_err=1, dmem_req=0, stalls held; a later dmem_ready=1 has no effect until rst.
- **Saturation:** force stall_cycles to 0xFFFFFFFE, then 3 stall cycles → reads 0xFFFFFFFF.
